// File: rtl/reg_map_arbiter.sv
// reg_map_arbiter
//   Shared register bank written by two sources: the I2C slave core
//   (unstallable single-cycle strobes, buffered in a one-entry pending slot)
//   and the host command path (valid/ready). At most one write commits per
//   clock. The host gets a starvation guard, and a registered host read port
//   is provided.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i2c_wr_stb/addr/wdata      I2C write strobe, address and data
//   i2c_rdata                  combinational read of reg[i2c_addr] (0 if out of range)
//   host_wr_valid/ready        host write handshake (ready is a combinational grant)
//   host_wr_addr/data          host write address and data
//   host_rd_req/addr           host read request (one per cycle)
//   host_rd_valid/data         read response, one cycle after the request
//   regs_flat                  all registers, reg i at [8i+7:8i]
//   commit_valid/src/addr      registered description of the write taken at the last edge
//   ovf, ovf_clr               sticky dropped-I2C-strobe flag and its clear
module reg_map_arbiter #(
  parameter int         NUM_REGS     = 4,
  parameter int         STARVE_LIMIT = 2,
  parameter logic [7:0] REG_RESET    = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i2c_wr_stb,
  input  logic [7:0]              i2c_addr,
  input  logic [7:0]              i2c_wdata,
  output logic [7:0]              i2c_rdata,
  input  logic                    host_wr_valid,
  output logic                    host_wr_ready,
  input  logic [7:0]              host_wr_addr,
  input  logic [7:0]              host_wr_data,
  input  logic                    host_rd_req,
  input  logic [7:0]              host_rd_addr,
  output logic                    host_rd_valid,
  output logic [7:0]              host_rd_data,
  output logic [8*NUM_REGS-1:0]   regs_flat,
  output logic                    commit_valid,
  output logic                    commit_src,
  output logic [7:0]              commit_addr,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  // A limit of 0 still needs a 1-bit counter; it simply never leaves 0,
  // which makes the host win whenever it is valid.
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [8:0]    NUM_REGS_9 = 9'(NUM_REGS);

  logic [7:0]    regs [NUM_REGS];
  logic          pend_v;
  logic [7:0]    pend_addr;
  logic [7:0]    pend_data;
  logic [CW-1:0] starve_cnt;

  logic          host_grant;
  logic          i2c_grant;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    rd_value;
  logic          i2c_drop;

  function automatic logic in_range(input logic [7:0] addr);
    return ({1'b0, addr} < NUM_REGS_9);
  endfunction

  // Grant: host wins when the I2C slot is empty or it has lost enough times.
  always_comb begin
    host_grant = host_wr_valid && ((starve_cnt == STARVE_MAX) || !pend_v);
    i2c_grant  = pend_v && !host_grant;
    wr_en      = host_grant || i2c_grant;
    wr_addr    = host_grant ? host_wr_addr : pend_addr;
    wr_data    = host_grant ? host_wr_data : pend_data;
    // A strobe is lost only when the slot is occupied and not draining now.
    i2c_drop   = i2c_wr_stb && pend_v && !i2c_grant;
  end

  assign host_wr_ready = host_grant;

  always_comb begin
    i2c_rdata = 8'h00;
    if (in_range(i2c_addr)) i2c_rdata = regs[i2c_addr[AW-1:0]];
  end

  always_comb begin
    rd_value = 8'h00;
    if (in_range(host_rd_addr)) rd_value = regs[host_rd_addr[AW-1:0]];
  end

  // Register array; out-of-range writes still handshake but touch nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
    end else if (wr_en && in_range(wr_addr)) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[8*gi +: 8] = regs[gi];
    end
  endgenerate

  // Pending I2C slot: reloads when empty or when its entry drains this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_addr <= 8'h00;
      pend_data <= 8'h00;
    end else if (i2c_wr_stb && (!pend_v || i2c_grant)) begin
      pend_v    <= 1'b1;
      pend_addr <= i2c_addr;
      pend_data <= i2c_wdata;
    end else if (i2c_grant) begin
      pend_v    <= 1'b0;
    end
  end

  // Counts consecutive host losses; cannot exceed the limit because the
  // host is granted as soon as the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (host_wr_valid && !host_grant) begin
      starve_cnt <= starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Setting wins over clearing so a drop in the clear cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (i2c_drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // src/addr hold the last committed write; valid marks the edge it happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_src   <= 1'b0;
      commit_addr  <= 8'h00;
    end else begin
      commit_valid <= wr_en;
      if (wr_en) begin
        commit_src  <= host_grant;
        commit_addr <= wr_addr;
      end
    end
  end

  // Read samples pre-write contents: regs still holds the old value here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rd_valid <= 1'b0;
      host_rd_data  <= 8'h00;
    end else begin
      host_rd_valid <= host_rd_req;
      if (host_rd_req) host_rd_data <= rd_value;
    end
  end

endmodule

// File: tb/tb_reg_map_arbiter.sv
// tb_reg_map_arbiter
//   Directed stimulus with a scoreboard: expected commits and read responses
//   are queued as stimulus is issued; a negedge monitor pops and compares
//   them whenever the DUT reports a commit or a read response.
module tb_reg_map_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i2c_wr_stb;
  logic [7:0]  i2c_addr;
  logic [7:0]  i2c_wdata;
  logic [7:0]  i2c_rdata;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [7:0]  host_wr_addr;
  logic [7:0]  host_wr_data;
  logic        host_rd_req;
  logic [7:0]  host_rd_addr;
  logic        host_rd_valid;
  logic [7:0]  host_rd_data;
  logic [31:0] regs_flat;
  logic        commit_valid;
  logic        commit_src;
  logic [7:0]  commit_addr;
  logic        ovf;
  logic        ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_commit_q[$];   // {src, addr}
  logic [7:0] exp_rd_q[$];

  reg_map_arbiter #(
    .NUM_REGS     (4),
    .STARVE_LIMIT (2),
    .REG_RESET    (8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i2c_wr_stb    (i2c_wr_stb),
    .i2c_addr      (i2c_addr),
    .i2c_wdata     (i2c_wdata),
    .i2c_rdata     (i2c_rdata),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_rd_req   (host_rd_req),
    .host_rd_addr  (host_rd_addr),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .regs_flat     (regs_flat),
    .commit_valid  (commit_valid),
    .commit_src    (commit_src),
    .commit_addr   (commit_addr),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (commit_valid) begin
        if (exp_commit_q.size() == 0) begin
          chk("commit_unexpected", {23'd0, commit_src, commit_addr}, 32'h0);
        end else begin
          logic [8:0] e;
          e = exp_commit_q.pop_front();
          $display("commit src=%0d addr=0x%02h (expected src=%0d addr=0x%02h)",
                   commit_src, commit_addr, e[8], e[7:0]);
          chk("commit", {23'd0, commit_src, commit_addr}, {23'd0, e});
        end
      end
      if (host_rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          chk("read_unexpected", {24'd0, host_rd_data}, 32'h0);
        end else begin
          logic [7:0] r;
          r = exp_rd_q.pop_front();
          $display("read data=0x%02h (expected 0x%02h)", host_rd_data, r);
          chk("read_data", {24'd0, host_rd_data}, {24'd0, r});
        end
      end
    end
  end

  // Strobe addresses/data, expected host grant, ovf_clr and ovf after each edge.
  logic [7:0] s3_addr [6] = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02};
  logic [7:0] s3_data [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  logic       s3_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       s3_clr  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       s3_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [8:0] s3_cmt  [6] = '{9'h103, 9'h000, 9'h001, 9'h103, 9'h002, 9'h001};

  initial begin
    rst_n = 1'b0; i2c_wr_stb = 1'b0; i2c_addr = 8'h00; i2c_wdata = 8'h00;
    host_wr_valid = 1'b0; host_wr_addr = 8'h00; host_wr_data = 8'h00;
    host_rd_req = 1'b0; host_rd_addr = 8'h00; ovf_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_regs", regs_flat, 32'h0);
    chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("rst_commit_src", {31'd0, commit_src}, 32'd0);
    chk("rst_commit_addr", {24'd0, commit_addr}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_rd_valid", {31'd0, host_rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, host_rd_data}, 32'd0);
    chk("rst_ready_idle", {31'd0, host_wr_ready}, 32'd0);
    host_wr_valid = 1'b1; #1;
    chk("rst_ready_valid", {31'd0, host_wr_ready}, 32'd1);
    host_wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;

    // Host write 0xA5 to addr 2, no I2C traffic
    host_wr_valid = 1'b1; host_wr_addr = 8'h02; host_wr_data = 8'hA5; #1;
    chk("s1_ready", {31'd0, host_wr_ready}, 32'd1);
    exp_commit_q.push_back(9'h102);
    step();
    host_wr_valid = 1'b0;
    chk("s1_reg2", {24'd0, regs_flat[23:16]}, 32'hA5);

    // I2C strobe during continuous host writes
    i2c_wr_stb = 1'b1; i2c_addr = 8'h01; i2c_wdata = 8'h3C;
    host_wr_valid = 1'b1; host_wr_addr = 8'h00; host_wr_data = 8'h10; #1;
    chk("s2_ready_a", {31'd0, host_wr_ready}, 32'd1);
    exp_commit_q.push_back(9'h100);
    step();
    i2c_wr_stb = 1'b0; host_wr_data = 8'h20; #1;
    chk("s2_ready_b", {31'd0, host_wr_ready}, 32'd0);
    exp_commit_q.push_back(9'h001);
    step();
    #1;
    chk("s2_ready_c", {31'd0, host_wr_ready}, 32'd1);
    exp_commit_q.push_back(9'h100);
    step();
    host_wr_valid = 1'b0;
    chk("s2_regs", regs_flat, 32'h00A53C20);

    // Back-to-back strobes against a waiting host
    host_wr_valid = 1'b1; host_wr_addr = 8'h03; host_wr_data = 8'h11;
    for (int i = 0; i < 6; i++) begin
      i2c_wr_stb = 1'b1; i2c_addr = s3_addr[i]; i2c_wdata = s3_data[i]; ovf_clr = s3_clr[i];
      #1;
      chk($sformatf("s3_ready_%0d", i), {31'd0, host_wr_ready}, {31'd0, s3_rdy[i]});
      exp_commit_q.push_back(s3_cmt[i]);
      step();
      chk($sformatf("s3_ovf_%0d", i), {31'd0, ovf}, {31'd0, s3_ovf[i]});
    end
    i2c_wr_stb = 1'b0; ovf_clr = 1'b0; #1;
    chk("s3_ready_forced", {31'd0, host_wr_ready}, 32'd1);
    exp_commit_q.push_back(9'h103);
    step();
    host_wr_valid = 1'b0;
    exp_commit_q.push_back(9'h002);
    step();
    chk("s3_regs", regs_flat, 32'h11464541);

    // Read old value on the same edge as a write, then the new one
    host_wr_valid = 1'b1; host_wr_addr = 8'h03; host_wr_data = 8'h77;
    host_rd_req = 1'b1; host_rd_addr = 8'h03; #1;
    chk("s4_ready", {31'd0, host_wr_ready}, 32'd1);
    exp_commit_q.push_back(9'h103);
    exp_rd_q.push_back(8'h11);
    step();
    host_wr_valid = 1'b0;
    chk("s4_rd_valid_1", {31'd0, host_rd_valid}, 32'd1);
    exp_rd_q.push_back(8'h77);
    step();
    host_rd_req = 1'b0;
    chk("s4_rd_valid_2", {31'd0, host_rd_valid}, 32'd1);
    step();
    chk("s4_rd_idle", {31'd0, host_rd_valid}, 32'd0);

    // Out-of-range write and read
    host_wr_valid = 1'b1; host_wr_addr = 8'h09; host_wr_data = 8'hEE;
    host_rd_req = 1'b1; host_rd_addr = 8'h09; i2c_addr = 8'h09; #1;
    chk("s5_ready", {31'd0, host_wr_ready}, 32'd1);
    chk("s5_i2c_rdata_oor", {24'd0, i2c_rdata}, 32'h00);
    exp_commit_q.push_back(9'h109);
    exp_rd_q.push_back(8'h00);
    step();
    host_wr_valid = 1'b0; host_rd_req = 1'b0;
    chk("s5_regs_host", regs_flat, 32'h77464541);
    i2c_wr_stb = 1'b1; i2c_addr = 8'h09; i2c_wdata = 8'hDD;
    exp_commit_q.push_back(9'h009);
    step();
    i2c_wr_stb = 1'b0; i2c_addr = 8'h01; #1;
    chk("s5_i2c_rdata_1", {24'd0, i2c_rdata}, 32'h45);
    step();
    step();
    chk("s5_regs_i2c", regs_flat, 32'h77464541);

    // Reset while an I2C entry is pending and the host is mid-burst
    i2c_wr_stb = 1'b1; i2c_addr = 8'h00; i2c_wdata = 8'h99;
    host_wr_valid = 1'b1; host_wr_addr = 8'h01; host_wr_data = 8'h55;
    host_rd_req = 1'b1; host_rd_addr = 8'h01; #1;
    chk("s6_ready_a", {31'd0, host_wr_ready}, 32'd1);
    exp_commit_q.push_back(9'h101);
    exp_rd_q.push_back(8'h45);
    step();
    i2c_wr_stb = 1'b0; host_rd_req = 1'b0; host_wr_data = 8'h56; #1;
    chk("s6_ready_b", {31'd0, host_wr_ready}, 32'd0);
    @(negedge clk);
    #1; rst_n = 1'b0; #1;
    chk("s6_rst_regs", regs_flat, 32'h0);
    chk("s6_rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("s6_rst_commit_src", {31'd0, commit_src}, 32'd0);
    chk("s6_rst_commit_addr", {24'd0, commit_addr}, 32'd0);
    chk("s6_rst_rd_data", {24'd0, host_rd_data}, 32'd0);
    chk("s6_rst_rd_valid", {31'd0, host_rd_valid}, 32'd0);
    chk("s6_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("s6_rst_ready", {31'd1 & 31'd0, host_wr_ready}, 32'd1);
    host_wr_valid = 1'b0;
    @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) step();
    chk("s6_regs_after", regs_flat, 32'h0);
    chk("s6_i2c_rdata", {24'd0, i2c_rdata}, 32'h00);

    chk("commit_q_drained", exp_commit_q.size(), 32'd0);
    chk("read_q_drained", exp_rd_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
